// File: rtl/ddr3_cmd_arbiter_if.sv
// Command/data handshake bundle between the arbiter, the command/data FIFOs and the MIG app port.
interface ddr3_cmd_arbiter_if #(
  parameter int ADDR_WIDTH = 28,
  parameter int BL_WIDTH   = 8
);
  localparam int CMD_WIDTH = 3 + BL_WIDTH + ADDR_WIDTH;

  logic                  init_calib_complete;
  logic                  wr_cmd_empty;
  logic                  wr_cmd_rden;
  logic [CMD_WIDTH-1:0]  wr_cmd_dout;
  logic                  rd_cmd_empty;
  logic                  rd_cmd_rden;
  logic [CMD_WIDTH-1:0]  rd_cmd_dout;
  logic [BL_WIDTH:0]     wr_data_cnt;
  logic                  wr_data_rden;
  logic                  app_en;
  logic [2:0]            app_cmd;
  logic [ADDR_WIDTH-1:0] app_addr;
  logic                  app_rdy;
  logic                  app_wdf_wren;
  logic                  app_wdf_end;
  logic                  app_wdf_rdy;
  logic                  busy;
  logic                  wr_done;
  logic                  rd_done;

  modport master (
    input  init_calib_complete, wr_cmd_empty, wr_cmd_dout, rd_cmd_empty, rd_cmd_dout,
           wr_data_cnt, app_rdy, app_wdf_rdy,
    output wr_cmd_rden, rd_cmd_rden, wr_data_rden, app_en, app_cmd, app_addr,
           app_wdf_wren, app_wdf_end, busy, wr_done, rd_done
  );

  modport slave (
    output init_calib_complete, wr_cmd_empty, wr_cmd_dout, rd_cmd_empty, rd_cmd_dout,
           wr_data_cnt, app_rdy, app_wdf_rdy,
    input  wr_cmd_rden, rd_cmd_rden, wr_data_rden, app_en, app_cmd, app_addr,
           app_wdf_wren, app_wdf_end, busy, wr_done, rd_done
  );
endinterface

// File: rtl/ddr3_cmd_arbiter.sv
// Round-robin write/read command arbiter feeding the MIG app interface from two FWFT command FIFOs.
//   state  | meaning
//   IDLE   | no burst active; may grant a pending write or read when calibrated
//   WR_RUN | issuing write commands and write-data beats for the latched burst
//   RD_RUN | issuing read commands for the latched burst
module ddr3_cmd_arbiter #(
  parameter int ADDR_WIDTH = 28,
  parameter int BL_WIDTH   = 8,
  parameter int ADDR_STEP  = 8
) (
  input  logic               I_Clk,
  input  logic               I_Rst_n,
  ddr3_cmd_arbiter_if.master bus
);
  localparam int CW        = BL_WIDTH + 1;
  localparam int CMD_WIDTH = 3 + BL_WIDTH + ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, WR_RUN, RD_RUN} state_t;

  state_t                state;
  logic [BL_WIDTH-1:0]   bl_q;
  logic [CW-1:0]         cmd_cnt;
  logic [CW-1:0]         data_cnt;
  logic                  last_wr;
  logic                  app_en;
  logic                  wdf_wren;
  logic [2:0]            app_cmd;
  logic [ADDR_WIDTH-1:0] app_addr;
  logic                  busy;
  logic                  wr_done;
  logic                  rd_done;

  logic [BL_WIDTH-1:0]   wr_bl;
  logic [BL_WIDTH-1:0]   rd_bl;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  wr_pend;
  logic                  rd_pend;
  logic                  grant_ok;
  logic                  grant_wr;
  logic                  grant_rd;
  logic                  cmd_acc;
  logic                  dat_acc;
  logic [CW-1:0]         cmd_nxt;
  logic [CW-1:0]         dat_nxt;
  logic [CW-1:0]         bl_ext;
  logic                  unused_cmd_bits;

  assign wr_bl   = bus.wr_cmd_dout[ADDR_WIDTH +: BL_WIDTH];
  assign rd_bl   = bus.rd_cmd_dout[ADDR_WIDTH +: BL_WIDTH];
  assign wr_addr = bus.wr_cmd_dout[ADDR_WIDTH-1:0];
  assign rd_addr = bus.rd_cmd_dout[ADDR_WIDTH-1:0];
  // The FIFO's own command field is ignored; direction alone selects the app command.
  assign unused_cmd_bits = ^{bus.wr_cmd_dout[CMD_WIDTH-1 -: 3], bus.rd_cmd_dout[CMD_WIDTH-1 -: 3]};

  assign wr_pend  = !bus.wr_cmd_empty && (bus.wr_data_cnt >= {1'b0, wr_bl});
  assign rd_pend  = !bus.rd_cmd_empty;
  // Reset gates the combinational pops so every output is low while reset is held.
  assign grant_ok = I_Rst_n && bus.init_calib_complete && (state == IDLE);
  assign grant_wr = grant_ok && wr_pend && (!rd_pend || !last_wr);
  assign grant_rd = grant_ok && rd_pend && !grant_wr;

  assign cmd_acc = app_en & bus.app_rdy;
  assign dat_acc = wdf_wren & bus.app_wdf_rdy;
  assign cmd_nxt = cmd_cnt + {{BL_WIDTH{1'b0}}, cmd_acc};
  assign dat_nxt = data_cnt + {{BL_WIDTH{1'b0}}, dat_acc};
  assign bl_ext  = {1'b0, bl_q};

  always_ff @(posedge I_Clk or negedge I_Rst_n) begin
    if (!I_Rst_n) begin
      state    <= IDLE;
      bl_q     <= '0;
      cmd_cnt  <= '0;
      data_cnt <= '0;
      last_wr  <= 1'b0;
      app_en   <= 1'b0;
      wdf_wren <= 1'b0;
      app_cmd  <= 3'b000;
      app_addr <= '0;
      busy     <= 1'b0;
      wr_done  <= 1'b0;
      rd_done  <= 1'b0;
    end else begin
      wr_done <= 1'b0;
      rd_done <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_wr) begin
            bl_q     <= wr_bl;
            app_addr <= wr_addr;
            app_cmd  <= 3'b000;
            cmd_cnt  <= '0;
            data_cnt <= '0;
            last_wr  <= 1'b1;
            if (wr_bl == '0) begin
              wr_done <= 1'b1;
            end else begin
              state    <= WR_RUN;
              busy     <= 1'b1;
              app_en   <= 1'b1;
              wdf_wren <= 1'b1;
            end
          end else if (grant_rd) begin
            bl_q     <= rd_bl;
            app_addr <= rd_addr;
            app_cmd  <= 3'b001;
            cmd_cnt  <= '0;
            data_cnt <= '0;
            last_wr  <= 1'b0;
            if (rd_bl == '0) begin
              rd_done <= 1'b1;
            end else begin
              state  <= RD_RUN;
              busy   <= 1'b1;
              app_en <= 1'b1;
            end
          end
        end
        WR_RUN: begin
          cmd_cnt  <= cmd_nxt;
          data_cnt <= dat_nxt;
          if (cmd_acc) app_addr <= app_addr + ADDR_WIDTH'(ADDR_STEP);
          app_en   <= (cmd_nxt < bl_ext);
          wdf_wren <= (dat_nxt < bl_ext);
          // Commands and data beats progress independently; the burst ends when both are done.
          if ((cmd_nxt == bl_ext) && (dat_nxt == bl_ext)) begin
            state   <= IDLE;
            busy    <= 1'b0;
            wr_done <= 1'b1;
          end
        end
        RD_RUN: begin
          cmd_cnt <= cmd_nxt;
          if (cmd_acc) app_addr <= app_addr + ADDR_WIDTH'(ADDR_STEP);
          app_en <= (cmd_nxt < bl_ext);
          if (cmd_nxt == bl_ext) begin
            state   <= IDLE;
            busy    <= 1'b0;
            rd_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.wr_cmd_rden  = grant_wr;
  assign bus.rd_cmd_rden  = grant_rd;
  assign bus.wr_data_rden = dat_acc;
  assign bus.app_en       = app_en;
  assign bus.app_cmd      = app_cmd;
  assign bus.app_addr     = app_addr;
  assign bus.app_wdf_wren = wdf_wren;
  assign bus.app_wdf_end  = wdf_wren;
  assign bus.busy         = busy;
  assign bus.wr_done      = wr_done;
  assign bus.rd_done      = rd_done;
endmodule

// File: tb/tb_ddr3_cmd_arbiter.sv
// Scoreboard bench for ddr3_cmd_arbiter: FIFO models, round-robin reference plan, negedge monitor.
module tb_ddr3_cmd_arbiter;
  localparam int AW   = 28;
  localparam int BW   = 8;
  localparam int STEP = 8;
  localparam int LIM  = 20000;

  typedef logic [38:0] entry_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ddr3_cmd_arbiter_if #(.ADDR_WIDTH(AW), .BL_WIDTH(BW)) bus();
  ddr3_cmd_arbiter #(.ADDR_WIDTH(AW), .BL_WIDTH(BW), .ADDR_STEP(STEP)) dut (
    .I_Clk(clk), .I_Rst_n(rst_n), .bus(bus));

  entry_t      wr_q[$], rd_q[$], stage_wr[$], stage_rd[$];
  logic [30:0] exp_cmd_q[$];
  bit          exp_done_q[$];
  int          data_avail = 0, exp_beats = 0, beats_seen = 0, cmd_accepts = 0;
  int          tests = 0, fails = 0;
  int          cal_mode = 0, rdy_mode = 0;
  bit          pop_wr = 0, pop_rd = 0, pop_dat = 0, model_last_wr = 0;

  task automatic check(string name, longint act, longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic entry_t mk(int bl, logic [27:0] addr);
    entry_t e;
    e = {3'($urandom_range(0, 7)), 8'(bl), addr};
    return e;
  endfunction

  // Reference: serve staged entries in round-robin order, expanding each into its app commands.
  function automatic void plan(bit add_data);
    while (stage_wr.size() != 0 || stage_rd.size() != 0) begin
      bit     take_wr;
      entry_t e;
      int     bl;
      longint base;
      take_wr = (stage_wr.size() != 0) && (stage_rd.size() == 0 || !model_last_wr);
      e = take_wr ? stage_wr.pop_front() : stage_rd.pop_front();
      bl = int'(e[35:28]);
      base = longint'(e[27:0]);
      if (take_wr) begin
        wr_q.push_back(e);
        exp_beats += bl;
        if (add_data) data_avail += bl;
      end else begin
        rd_q.push_back(e);
      end
      for (int k = 0; k < bl; k++)
        exp_cmd_q.push_back({take_wr ? 3'b000 : 3'b001, 28'((base + k * STEP) % (64'd1 << AW))});
      exp_done_q.push_back(take_wr);
      model_last_wr = take_wr;
    end
  endfunction

  function automatic void update_fifo();
    bus.wr_cmd_empty = (wr_q.size() == 0);
    bus.wr_cmd_dout  = (wr_q.size() == 0) ? '0 : wr_q[0];
    bus.rd_cmd_empty = (rd_q.size() == 0);
    bus.rd_cmd_dout  = (rd_q.size() == 0) ? '0 : rd_q[0];
    bus.wr_data_cnt  = 9'(data_avail);
  endfunction

  // Driver: applies pops observed on the previous negedge, then drives fresh inputs.
  initial begin
    bus.init_calib_complete = 1'b0;
    bus.app_rdy = 1'b1;
    bus.app_wdf_rdy = 1'b1;
    update_fifo();
    forever begin
      @(posedge clk);
      #1;
      if (pop_wr && wr_q.size() != 0) void'(wr_q.pop_front());
      if (pop_rd && rd_q.size() != 0) void'(rd_q.pop_front());
      if (pop_dat) data_avail--;
      bus.app_rdy     = (rdy_mode == 0) ? 1'b1 : ($urandom_range(0, 99) >= 30);
      bus.app_wdf_rdy = (rdy_mode == 0) ? 1'b1 : ($urandom_range(0, 99) >= 30);
      bus.init_calib_complete = (cal_mode == 2) ? ($urandom_range(0, 3) != 0) : (cal_mode == 1);
      update_fifo();
    end
  end

  // Monitor: compares every presented command, data beat and done pulse with the scoreboard.
  initial begin
    bit stall_cmd = 0, stall_wdf = 0;
    forever begin
      @(negedge clk);
      pop_wr  = rst_n && bus.wr_cmd_rden;
      pop_rd  = rst_n && bus.rd_cmd_rden;
      pop_dat = rst_n && bus.wr_data_rden;
      if (!rst_n) begin
        stall_cmd = 0;
        stall_wdf = 0;
        beats_seen = 0;
      end else begin
        if (stall_cmd) check("app_en_held", bus.app_en, 1);
        if (stall_wdf) check("wdf_wren_held", bus.app_wdf_wren, 1);
        if (bus.app_en) begin
          if (exp_cmd_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_app_cmd: got cmd %0d addr %0h, expected no command",
                     bus.app_cmd, bus.app_addr);
          end else begin
            check("app_cmd_addr", {bus.app_cmd, bus.app_addr}, exp_cmd_q[0]);
            if (bus.app_rdy) begin
              void'(exp_cmd_q.pop_front());
              cmd_accepts++;
            end
          end
        end
        if (bus.app_wdf_wren || bus.app_wdf_end)
          check("wdf_end_with_wren", {bus.app_wdf_wren, bus.app_wdf_end}, 2'b11);
        if (bus.wr_data_rden || bus.app_wdf_wren)
          check("wr_data_rden", bus.wr_data_rden, bus.app_wdf_wren && bus.app_wdf_rdy);
        if (bus.app_wdf_wren) begin
          if (beats_seen >= exp_beats) begin
            tests++; fails++;
            $display("FAIL unexpected_wdf_beat: got beat %0d, expected only %0d", beats_seen + 1, exp_beats);
          end else if (bus.app_wdf_rdy) begin
            beats_seen++;
          end
        end
        if (bus.wr_done || bus.rd_done) begin
          if (exp_done_q.size() == 0 || (bus.wr_done && bus.rd_done)) begin
            tests++; fails++;
            $display("FAIL unexpected_done: got wr %0d rd %0d, expected none", bus.wr_done, bus.rd_done);
          end else begin
            check("done_dir_is_wr", bus.wr_done, exp_done_q.pop_front());
          end
        end
        stall_cmd = bus.app_en && !bus.app_rdy;
        stall_wdf = bus.app_wdf_wren && !bus.app_wdf_rdy;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_outputs_zero(string name);
    check(name, {bus.app_en, bus.app_cmd, bus.app_addr, bus.app_wdf_wren, bus.app_wdf_end,
                 bus.wr_data_rden, bus.wr_cmd_rden, bus.rd_cmd_rden, bus.busy,
                 bus.wr_done, bus.rd_done}, 0);
  endtask

  task automatic clear_tb_state();
    wr_q.delete(); rd_q.delete(); stage_wr.delete(); stage_rd.delete();
    exp_cmd_q.delete(); exp_done_q.delete();
    exp_beats = 0; data_avail = 0; model_last_wr = 0;
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0;
    clear_tb_state();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  task automatic drain(string name);
    int n = 0;
    while (!(exp_cmd_q.size() == 0 && exp_done_q.size() == 0 && wr_q.size() == 0 &&
             rd_q.size() == 0 && !bus.busy && beats_seen == exp_beats) && n < LIM) begin
      tick();
      n++;
    end
    check({name, "_completes"}, n < LIM, 1);
    check({name, "_beats"}, beats_seen, exp_beats);
  endtask

  initial begin
    int start, n;
    repeat (3) @(posedge clk);
    #2 check_outputs_zero("reset_outputs");
    @(posedge clk);
    #3 rst_n = 1'b1;

    cal_mode = 1;
    stage_wr.push_back(mk(64, 28'h0));
    plan(1);
    drain("wr_bl64");
    stage_rd.push_back(mk(64, 28'h0));
    plan(1);
    drain("rd_bl64");

    do_reset();
    cal_mode = 0;
    for (int i = 0; i < 4; i++) begin
      stage_wr.push_back(mk($urandom_range(1, 8), 28'($urandom)));
      stage_rd.push_back(mk($urandom_range(1, 8), 28'($urandom)));
    end
    plan(1);
    repeat (5) tick();
    check("calib_gate_busy", bus.busy, 0);
    check("calib_gate_wr_q", wr_q.size(), 4);
    cal_mode = 1;
    drain("rr_4x4");

    rdy_mode = 1;
    for (int r = 0; r < 4; r++) begin
      cal_mode = 0;
      for (int i = $urandom_range(1, 5); i > 0; i--) stage_wr.push_back(mk($urandom_range(0, 20), 28'($urandom)));
      for (int i = $urandom_range(1, 5); i > 0; i--) stage_rd.push_back(mk($urandom_range(0, 20), 28'($urandom)));
      plan(1);
      cal_mode = 2;
      drain("random_stall");
    end
    rdy_mode = 0;
    cal_mode = 1;

    stage_wr.push_back(mk(2, 28'hFFFFFF8));
    stage_wr.push_back(mk(0, 28'h0000123));
    stage_rd.push_back(mk(0, 28'h0000456));
    plan(1);
    drain("wrap_and_bl0");

    stage_wr.push_back(mk(10, 28'h0000800));
    plan(0);
    data_avail = 5;
    repeat (20) tick();
    check("data_gate_wr_q", wr_q.size(), 1);
    check("data_gate_busy", bus.busy, 0);
    data_avail += 5;
    drain("data_gate");

    stage_wr.push_back(mk(64, 28'h0001000));
    plan(1);
    start = cmd_accepts;
    n = 0;
    while (cmd_accepts - start < 10 && n < 1000) begin
      tick();
      n++;
    end
    check("reached_10_cmds", cmd_accepts - start >= 10, 1);
    rst_n = 1'b0;
    #1 check_outputs_zero("mid_burst_reset_outputs");
    clear_tb_state();
    stage_rd.push_back(mk(1, 28'h0000040));
    plan(1);
    repeat (3) tick();
    check("no_pop_in_reset", bus.rd_cmd_rden, 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    #1 check("first_edge_grant", bus.rd_cmd_rden, 1);
    drain("post_reset_read");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
